net_input_assembler: RTL
========================

// Module: net_input_assembler
// PURPOSE
//  Upstream feeder of the LUTNN top: accepts a raster-order grayscale pixel stream (valid/ready),
//  binarizes each pixel against a threshold and assembles one NET_INPUTS-bit frame vector.
//  The vector drives top.NET_I; a valid/ready pair hands each completed frame to the consumer.
//  Two-deep: an assembly buffer fills while the previous frame is held on the output register.
// PARAMETERS
//  IMG_W      20   image width, pixels
//  IMG_H      20   image height, pixels
//  NET_INPUTS 400  frame vector width; must equal IMG_W*IMG_H
//  PIX_W      8    grayscale pixel width
//  THRESH     128  binarization threshold; bit = (PIX_DATA_I >= THRESH)
// PORTS
//  CLK          in   1           clock, all state on rising edge
//  RST_N        in   1           asynchronous active-low reset
//  PIX_VALID_I  in   1           pixel beat valid
//  PIX_READY_O  out  1           pixel beat accepted when VALID&READY
//  PIX_DATA_I   in   PIX_W       grayscale pixel, raster order (row 0 col 0 first)
//  PIX_LAST_I   in   1           marks last pixel of a frame
//  NET_VALID_O  out  1           NET_VEC_O holds a complete frame
//  NET_READY_I  in   1           consumer takes frame when NET_VALID_O&NET_READY_I
//  NET_VEC_O    out  NET_INPUTS  binarized frame -> top.NET_I
//  FRAME_ERR_O  out  1           one-cycle pulse: malformed frame discarded
//  FRAME_CNT_O  out  16          frames delivered (handshakes completed), wraps 0xFFFF->0
// BEHAVIOUR
//  Reset: PIX_READY_O=0 during reset, NET_VALID_O=0, NET_VEC_O=0, FRAME_ERR_O=0, FRAME_CNT_O=0,
//   pix_cnt=0, assembly buffer=0, state=S_FILL. Reset mid-frame drops the partial frame.
//  Bit order: accepted pixel k (0..NET_INPUTS-1) writes assembly bit k; pixel 0 -> bit 0 (LSB).
//  FSM S_FILL: each accepted beat writes bit, pix_cnt++.
//   - beat with pix_cnt==NET_INPUTS-1 and LAST=1: assembly (incl. this bit) copied to NET_VEC_O,
//     NET_VALID_O=1 next cycle; pix_cnt->0; assembly cleared. Latency: 1 cycle after last beat.
//   - beat with LAST=1 and pix_cnt<NET_INPUTS-1 (short frame): FRAME_ERR_O pulse, pix_cnt->0,
//     assembly cleared, stay S_FILL.
//   - beat with pix_cnt==NET_INPUTS-1 and LAST=0 (long frame): FRAME_ERR_O pulse, -> S_SYNC.
//  FSM S_SYNC: PIX_READY_O=1, beats discarded; beat with LAST=1 -> S_FILL, pix_cnt=0.
//  PIX_READY_O in S_FILL = ~(pix_cnt==NET_INPUTS-1 && NET_VALID_O && ~NET_READY_I);
//   i.e. only the completing beat stalls while the output is occupied and not being taken.
//   NET_READY_I->PIX_READY_O combinational path is intentional.
//  Output handshake: NET_VEC_O stable while NET_VALID_O=1 and NET_READY_I=0. On take:
//   NET_VALID_O->0 next cycle, FRAME_CNT_O++; if a completing beat is accepted the same cycle,
//   NET_VEC_O loads the new frame and NET_VALID_O stays 1 (back-to-back, no bubble).
//  Out-of-reset: PIX_READY_O=1 from first cycle after RST_N deasserts.
//  PIX_VALID_I=0 beats: no state change. PIX_DATA_I ignored unless accepted.
// STRUCTURE
//  net_pkg: NET_INPUTS, IMG_W, IMG_H, PIX_W, typedef logic [NET_INPUTS-1:0] net_vec_t,
//   typedef enum logic [0:0] {S_FILL, S_SYNC} asm_state_t. Shared with top and its bench.
//  pix_cnt width $clog2(NET_INPUTS). Flat module; threshold compare inline, no sub-module.
// TESTING
//  1 Stream MNIST seven (bit k=1 -> pixel 0xFF, else 0x00), LAST on beat 399, READY=1 ->
//    NET_VEC_O==400'h003C0007C...000FC one cycle later, NET_VALID_O=1, FRAME_CNT_O=1.
//  2 Pixels 127 and 128 with THRESH=128 -> bits 0 and 1; pixel 0xFF -> 1, 0x00 -> 0.
//  3 NET_READY_I=0, stream two back-to-back frames (seven, two) -> PIX_READY_O=0 only on beat 399
//    of frame 2, NET_VEC_O holds seven; raise READY -> two loads same cycle, no bubble, CNT=2.
//  4 LAST on beat 150 -> FRAME_ERR_O 1-cycle pulse, no NET_VALID_O; next 400-beat frame correct.
//  5 400 beats without LAST, 5 more, LAST on 6th -> ERR pulse at beat 399, beats dropped,
//    following MNIST_one frame delivered exactly.
//  6 Assert RST_N=0 at beat 200 mid-frame and while NET_VALID_O=1 -> all outputs 0 asynchronously,
//    next full frame (MNIST_zero) assembled correctly; FRAME_CNT_O 0xFFFF+1 -> 0.

Source files
------------

// File: rtl/net_pkg.sv
// rtl/net_pkg.sv - shared frame geometry and assembler state types
package net_pkg;

  localparam int unsigned IMG_W      = 20;
  localparam int unsigned IMG_H      = 20;
  localparam int unsigned NET_INPUTS = IMG_W * IMG_H;
  localparam int unsigned PIX_W      = 8;
  localparam int unsigned CNT_W      = $clog2(NET_INPUTS);

  typedef logic [NET_INPUTS-1:0] net_vec_t;

  typedef enum logic [0:0] {S_FILL, S_SYNC} asm_state_t;

endpackage

// File: rtl/net_input_assembler.sv
// rtl/net_input_assembler.sv - binarizes a raster pixel stream into one frame vector per image,
// double-buffered: assembly fills while the previous frame waits on the output register.
module net_input_assembler
  import net_pkg::*;
#(
  parameter int unsigned THRESH = 128
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             pix_valid_i,
  output logic             pix_ready_o,
  input  logic [PIX_W-1:0] pix_data_i,
  input  logic             pix_last_i,
  output logic             net_valid_o,
  input  logic             net_ready_i,
  output net_vec_t         net_vec_o,
  output logic             frame_err_o,
  output logic [15:0]      frame_cnt_o
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NET_INPUTS - 1);

  asm_state_t       state_q, state_d;
  logic [CNT_W-1:0] pix_cnt_q, pix_cnt_d;
  net_vec_t         asm_q, asm_d;
  net_vec_t         vec_q, vec_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic [15:0]      frame_cnt_q, frame_cnt_d;

  logic last_slot;
  logic pix_bit;
  logic pix_acc;
  logic take;

  always_comb begin
    last_slot   = (pix_cnt_q == LAST_IDX);
    pix_bit     = (pix_data_i >= PIX_W'(THRESH));
    take        = valid_q & net_ready_i;
    // Only the completing beat has to wait for the output register to free up.
    pix_ready_o = rst_ni & ((state_q == S_SYNC) | ~(last_slot & valid_q & ~net_ready_i));
    pix_acc     = pix_valid_i & pix_ready_o;

    state_d     = state_q;
    pix_cnt_d   = pix_cnt_q;
    asm_d       = asm_q;
    vec_d       = vec_q;
    valid_d     = valid_q;
    err_d       = 1'b0;
    frame_cnt_d = frame_cnt_q;

    if (take) begin
      valid_d     = 1'b0;
      frame_cnt_d = frame_cnt_q + 16'd1;
    end

    if (pix_acc) begin
      if (state_q == S_SYNC) begin
        if (pix_last_i) begin
          state_d   = S_FILL;
          pix_cnt_d = '0;
        end
      end else begin
        asm_d[pix_cnt_q] = pix_bit;
        if (pix_last_i) begin
          if (last_slot) begin
            vec_d   = asm_d;
            valid_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
          pix_cnt_d = '0;
          asm_d     = '0;
        end else if (last_slot) begin
          err_d     = 1'b1;
          state_d   = S_SYNC;
          pix_cnt_d = '0;
          asm_d     = '0;
        end else begin
          pix_cnt_d = pix_cnt_q + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_FILL;
      pix_cnt_q   <= '0;
      asm_q       <= '0;
      vec_q       <= '0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      pix_cnt_q   <= pix_cnt_d;
      asm_q       <= asm_d;
      vec_q       <= vec_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign net_valid_o = valid_q;
  assign net_vec_o   = vec_q;
  assign frame_err_o = err_q;
  assign frame_cnt_o = frame_cnt_q;

endmodule
